// File: rtl/cpu_core_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_core_mc_if
// Purpose  : Instruction-fetch handshake between cpu_core_mc and its
//            instruction source (ROM / switch front-end).
// Revision : 1.0
// ============================================================================
interface cpu_core_mc_if #(
    parameter int PC_W = 8
);
    logic [7:0]      instruction;
    logic            instr_valid;
    logic [PC_W-1:0] instr_address;
    logic            instr_req;

    modport master (
        input  instruction,
        input  instr_valid,
        output instr_address,
        output instr_req
    );

    modport slave (
        output instruction,
        output instr_valid,
        input  instr_address,
        input  instr_req
    );
endinterface
`default_nettype wire

// File: rtl/cpu_core_mc.sv
`default_nettype none
// ============================================================================
// Module   : cpu_core_mc
// Purpose  : Parametrised multi-cycle 4-register core with fetch handshake,
//            conditional branch, HALT state and register debug port.
// Revision : 1.0
// ============================================================================
module cpu_core_mc #(
    parameter int DATA_W    = 8,
    parameter int PC_W      = 8,
    parameter int MEM_DEPTH = 32
) (
    input  wire logic              clock,
    input  wire logic              reset,
    cpu_core_mc_if.master          ibus,
    input  wire logic [1:0]        dbg_sel,
    output logic                   mem_write,
    output logic                   mem_read,
    output logic                   reg_write,
    output logic [1:0]             op,
    output logic                   halted,
    output logic [DATA_W-1:0]      dbg_data
);

    localparam int              c_ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [PC_W-1:0] c_PC_ONE = PC_W'(1);

    localparam logic [1:0] c_OP_ADD    = 2'b00;
    localparam logic [1:0] c_OP_LOAD   = 2'b01;
    localparam logic [1:0] c_OP_STORE  = 2'b10;
    localparam logic [1:0] c_OP_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [PC_W-1:0]     r_pc;
    logic [7:0]          r_ir;
    logic [DATA_W-1:0]   r_regs [4];
    logic [DATA_W-1:0]   r_mem  [MEM_DEPTH];

    logic [1:0]          w_rs;
    logic [1:0]          w_rt;
    logic [1:0]          w_rd;
    logic [DATA_W-1:0]   w_simm;
    logic [PC_W-1:0]     w_simm_pc;
    logic [c_ADDR_W-1:0] w_addr;
    logic                w_is_halt;
    logic                w_taken;
    logic [PC_W-1:0]     w_pc_branch;

    assign w_rs      = r_ir[5:4];
    assign w_rt      = r_ir[3:2];
    assign w_rd      = r_ir[1:0];
    assign w_simm    = DATA_W'($signed(r_ir[1:0]));
    assign w_simm_pc = PC_W'($signed(r_ir[1:0]));
    // Effective address wraps in DATA_W first, then keeps only the index bits
    assign w_addr    = c_ADDR_W'(r_regs[w_rs] + w_simm);

    assign w_is_halt   = (r_ir[7:6] == c_OP_BRANCH) && !r_ir[2] && (r_ir[1:0] == 2'b11);
    assign w_taken     = !r_ir[2] || (r_regs[w_rs] == '0);
    assign w_pc_branch = w_taken ? (r_pc + w_simm_pc + c_PC_ONE) : (r_pc + c_PC_ONE);

    assign op                 = r_ir[7:6];
    assign ibus.instr_address = r_pc;
    assign ibus.instr_req     = (r_state == S_FETCH);
    assign halted             = (r_state == S_HALT);
    assign mem_write          = (r_state == S_EXEC) && (op == c_OP_STORE);
    assign mem_read           = (r_state == S_EXEC) && (op == c_OP_LOAD);
    assign reg_write          = (r_state == S_EXEC) && ((op == c_OP_ADD) || (op == c_OP_LOAD));
    assign dbg_data           = r_regs[dbg_sel];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (ibus.instr_valid) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = w_is_halt ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Datapath: every architectural update commits on the EXEC edge only
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
            r_ir <= '0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= DATA_W'(i);
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (ibus.instr_valid) begin
                        r_ir <= ibus.instruction;
                    end
                end
                S_EXEC: begin
                    case (r_ir[7:6])
                        c_OP_ADD: begin
                            r_regs[w_rd] <= r_regs[w_rs] + r_regs[w_rt];
                            r_pc         <= r_pc + c_PC_ONE;
                        end
                        c_OP_LOAD: begin
                            r_regs[w_rt] <= r_mem[w_addr];
                            r_pc         <= r_pc + c_PC_ONE;
                        end
                        c_OP_STORE: begin
                            r_mem[w_addr] <= r_regs[w_rt];
                            r_pc          <= r_pc + c_PC_ONE;
                        end
                        default: begin
                            if (!w_is_halt) begin
                                r_pc <= w_pc_branch;
                            end
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_core_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_core_mc
// Purpose  : Scoreboard testbench for cpu_core_mc against a reference model.
// Revision : 1.0
// ============================================================================
module tb_cpu_core_mc;

    localparam int DATA_W    = 8;
    localparam int PC_W      = 8;
    localparam int MEM_DEPTH = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        dbg_sel = 2'd0;
    logic              mem_write;
    logic              mem_read;
    logic              reg_write;
    logic [1:0]        op;
    logic              halted;
    logic [DATA_W-1:0] dbg_data;

    cpu_core_mc_if #(.PC_W(PC_W)) ibus ();

    cpu_core_mc #(
        .DATA_W    (DATA_W),
        .PC_W      (PC_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ibus      (ibus),
        .dbg_sel   (dbg_sel),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .reg_write (reg_write),
        .op        (op),
        .halted    (halted),
        .dbg_data  (dbg_data)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  pc;
        logic        halted;
        logic [2:0]  strb;
        logic [1:0]  op;
        logic [31:0] regs;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;

    logic [7:0] m_regs [4];
    logic [7:0] m_mem  [MEM_DEPTH];
    logic [7:0] m_pc;
    logic       m_halt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
        for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 8'(i);
        m_pc   = 8'd0;
        m_halt = 1'b0;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] exp_regs);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r);
            #1;
            check(tag, 32'(dbg_data), 32'(exp_regs[r*8 +: 8]));
        end
    endtask

    task automatic issue(input logic [7:0] ins, input int stall);
        exp_t       e;
        logic [1:0] rs, rt, rd;
        logic [7:0] simm;
        logic [4:0] a;
        for (int i = 0; i < stall; i++) begin
            ibus.instr_valid = 1'b0;
            @(negedge clock);
            check("stall_req", 32'(ibus.instr_req), 32'd1);
            check("stall_pc", 32'(ibus.instr_address), 32'(m_pc));
        end
        rs   = ins[5:4];
        rt   = ins[3:2];
        rd   = ins[1:0];
        simm = {{6{ins[1]}}, ins[1:0]};
        a    = 5'(m_regs[rs] + simm);
        e.op   = ins[7:6];
        e.strb = {ins[7:6] == 2'b10, ins[7:6] == 2'b01,
                  (ins[7:6] == 2'b00) || (ins[7:6] == 2'b01)};
        case (ins[7:6])
            2'b00: begin m_regs[rd] = m_regs[rs] + m_regs[rt]; m_pc = m_pc + 8'd1; end
            2'b01: begin m_regs[rt] = m_mem[a]; m_pc = m_pc + 8'd1; end
            2'b10: begin m_mem[a] = m_regs[rt]; m_pc = m_pc + 8'd1; end
            default: begin
                if (!ins[2] && ins[1:0] == 2'b11) m_halt = 1'b1;
                else if (!ins[2] || m_regs[rs] == 8'd0) m_pc = m_pc + simm + 8'd1;
                else m_pc = m_pc + 8'd1;
            end
        endcase
        e.pc     = m_pc;
        e.halted = m_halt;
        e.regs   = {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
        sb.push_back(e);

        ibus.instruction = ins;
        ibus.instr_valid = 1'b1;
        @(negedge clock);
        ibus.instr_valid = 1'b0;
        ibus.instruction = 8'($urandom);
        e = sb.pop_front();
        check("exec_req", 32'(ibus.instr_req), 32'd0);
        check("exec_op", 32'(op), 32'(e.op));
        check("exec_strb", 32'({mem_write, mem_read, reg_write}), 32'(e.strb));
        @(negedge clock);
        check("pc", 32'(ibus.instr_address), 32'(e.pc));
        check("halted", 32'(halted), 32'(e.halted));
        check("post_strb", 32'({mem_write, mem_read, reg_write}), 32'd0);
        check_regs("reg", e.regs);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(ibus.instr_req), 32'd1);
        check({tag, "_halt"}, 32'(halted), 32'd0);
        check({tag, "_strb"}, 32'({mem_write, mem_read, reg_write}), 32'd0);
        check({tag, "_op"}, 32'(op), 32'd0);
        check({tag, "_pc"}, 32'(ibus.instr_address), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ibus.instruction = 8'd0;
        ibus.instr_valid = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("rst");
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_reset_outputs("idle");
        end

        issue(8'h06, 0);
        issue(8'h4D, 1);
        issue(8'h3F, 0);
        issue(8'h8F, 2);
        issue(8'h4B, 0);
        issue(8'hC5, 0);
        issue(8'hC3, 1);

        for (int i = 0; i < 4; i++) begin
            ibus.instruction = 8'h06;
            ibus.instr_valid = 1'b1;
            @(negedge clock);
            check("halt_hold", 32'(halted), 32'd1);
            check("halt_pc", 32'(ibus.instr_address), 32'd7);
            check("halt_req", 32'(ibus.instr_req), 32'd0);
            check("halt_strb", 32'({mem_write, mem_read, reg_write}), 32'd0);
        end
        ibus.instr_valid = 1'b0;

        reset = 1'b1;
        #1;
        check_reset_outputs("rst2");
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        issue(8'h4D, 0);
        issue(8'h30, 0);
        issue(8'hC5, 1);
        issue(8'hC2, 0);
        while (m_pc != 8'd254) begin
            issue(8'hC1, int'($urandom_range(0, 1)));
        end
        issue(8'h06, 0);
        issue(8'h06, 0);
        issue(8'hC2, 0);
        issue(8'h8F, 0);
        issue(8'h4B, 0);

        ibus.instruction = 8'h30;
        ibus.instr_valid = 1'b1;
        @(negedge clock);
        ibus.instr_valid = 1'b0;
        check("abort_exec_wr", 32'(reg_write), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_regs("abort_reg", 32'd0);
        issue(8'h4B, 0);
        issue(8'h4D, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
